// File: rtl/ram_loader.sv
// ram_loader: bus-master program loader for the 16-byte SAP RAM.
// Takes program bytes over a valid/ready handshake and drives the shared bus,
// the MAR load strobe and the RAM write strobe while busy.
// Optional readback checksum pass: define RAM_LOADER_VERIFY_EN to compile it in.
// When it is undefined, output_enable and error are tied low.
module ram_loader #(
  parameter int         LENGTH     = 16,
  parameter logic [3:0] START_ADDR = 4'd0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_drive,
  output logic       load_addr_reg,
  output logic       control_signal,
  output logic       output_enable,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT_DATA,
    S_WRITE,
    S_NEXT
`ifdef RAM_LOADER_VERIFY_EN
    ,
    S_V_ADDR,
    S_V_READ,
    S_CHECK
`endif
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(LENGTH - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_index;
  logic [3:0] w_index_nx;
  logic [7:0] r_csum;
  logic [7:0] w_csum_nx;
  logic       r_done;
  logic       w_done_nx;
  logic       w_accept;
  logic       w_last;

  // Registered Moore outputs; r_bus_out doubles as the data register in WRITE.
  logic [7:0] r_bus_out;
  logic       r_bus_drive;
  logic       r_lar;
  logic       r_cs;
  logic       r_in_ready;
  logic       r_busy;
  logic [7:0] w_bus_out_nx;
  logic       w_drive_nx;
  logic       w_lar_nx;
  logic       w_cs_nx;
  logic       w_ready_nx;
  logic       w_oe_nx;
  logic [3:0] w_addr_nx;

`ifdef RAM_LOADER_VERIFY_EN
  logic [7:0] r_rsum;
  logic [7:0] w_rsum_nx;
  logic       r_error;
  logic       w_error_nx;
  logic       r_oe;
`else
  logic       w_unused_bus_in;
  assign w_unused_bus_in = ^bus_in;
`endif

  assign w_accept = in_valid & r_in_ready;
  assign w_last   = (r_index == LAST_IDX);

  // Next-state, index, checksum and sticky-flag logic.
  always_comb begin
    w_next     = r_state;
    w_index_nx = r_index;
    w_csum_nx  = r_csum;
    w_done_nx  = r_done;
`ifdef RAM_LOADER_VERIFY_EN
    w_rsum_nx  = r_rsum;
    w_error_nx = r_error;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next     = S_ADDR;
          w_index_nx = 4'd0;
          w_csum_nx  = 8'h00;
          w_done_nx  = 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
          w_rsum_nx  = 8'h00;
          w_error_nx = 1'b0;
`endif
        end
      end
      S_ADDR: w_next = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (w_accept) begin
          w_next    = S_WRITE;
          w_csum_nx = r_csum + in_data;
        end
      end
      S_WRITE: w_next = S_NEXT;
      S_NEXT: begin
        if (w_last) begin
`ifdef RAM_LOADER_VERIFY_EN
          w_next     = S_V_ADDR;
          w_index_nx = 4'd0;
`else
          w_next    = S_IDLE;
          w_done_nx = 1'b1;
`endif
        end else begin
          w_next     = S_ADDR;
          w_index_nx = r_index + 4'd1;
        end
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_V_ADDR: w_next = S_V_READ;
      S_V_READ: begin
        w_rsum_nx = r_rsum + bus_in;
        if (w_last) begin
          w_next = S_CHECK;
        end else begin
          w_next     = S_V_ADDR;
          w_index_nx = r_index + 4'd1;
        end
      end
      S_CHECK: begin
        w_error_nx = (r_rsum != r_csum);
        w_done_nx  = 1'b1;
        w_next     = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes line up with the state.
  always_comb begin
    w_bus_out_nx = 8'h00;
    w_drive_nx   = 1'b0;
    w_lar_nx     = 1'b0;
    w_cs_nx      = 1'b0;
    w_ready_nx   = 1'b0;
    w_oe_nx      = 1'b0;
    w_addr_nx    = START_ADDR + w_index_nx;
    case (w_next)
      S_ADDR: begin
        w_bus_out_nx = {4'b0000, w_addr_nx};
        w_drive_nx   = 1'b1;
        w_lar_nx     = 1'b1;
      end
      S_WAIT_DATA: w_ready_nx = 1'b1;
      S_WRITE: begin
        // WRITE is only entered on an accepted byte, so in_data is the byte to write.
        w_bus_out_nx = in_data;
        w_drive_nx   = 1'b1;
        w_cs_nx      = 1'b1;
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_V_ADDR: begin
        w_bus_out_nx = {4'b0000, w_addr_nx};
        w_drive_nx   = 1'b1;
        w_lar_nx     = 1'b1;
      end
      S_V_READ: w_oe_nx = 1'b1;
`endif
      default: w_bus_out_nx = 8'h00;
    endcase
  end

  // State, counters and output registers; clear aborts any sequence.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_index     <= 4'd0;
      r_csum      <= 8'h00;
      r_done      <= 1'b0;
      r_bus_out   <= 8'h00;
      r_bus_drive <= 1'b0;
      r_lar       <= 1'b0;
      r_cs        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
      r_rsum      <= 8'h00;
      r_error     <= 1'b0;
      r_oe        <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      r_index     <= w_index_nx;
      r_csum      <= w_csum_nx;
      r_done      <= w_done_nx;
      r_bus_out   <= w_bus_out_nx;
      r_bus_drive <= w_drive_nx;
      r_lar       <= w_lar_nx;
      r_cs        <= w_cs_nx;
      r_in_ready  <= w_ready_nx;
      r_busy      <= (w_next != S_IDLE);
`ifdef RAM_LOADER_VERIFY_EN
      r_rsum      <= w_rsum_nx;
      r_error     <= w_error_nx;
      r_oe        <= w_oe_nx;
`endif
    end
  end

  assign bus_out        = r_bus_out;
  assign bus_drive      = r_bus_drive;
  assign load_addr_reg  = r_lar;
  assign control_signal = r_cs;
  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign done           = r_done;
`ifdef RAM_LOADER_VERIFY_EN
  assign output_enable  = r_oe;
  assign error          = r_error;
`else
  assign output_enable  = 1'b0;
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed bench for ram_loader with two instances
// (LENGTH=16/START_ADDR=0 and LENGTH=4/START_ADDR=14), each with a RAM/MAR model.
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
  localparam int LAT_A = 97;
  localparam int LAT_B = 25;
  localparam int LAR_B = 8;
`else
  localparam int LAT_A = 64;
  localparam int LAT_B = 16;
  localparam int LAR_B = 4;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       a_start = 1'b0, a_valid = 1'b0, a_ready, a_drive, a_lar, a_cs, a_oe;
  logic       a_busy, a_done, a_error;
  logic [7:0] a_data, a_bus_in, a_bus_out;
  logic       b_start = 1'b0, b_valid = 1'b0, b_ready, b_drive, b_lar, b_cs, b_oe;
  logic       b_busy, b_done, b_error;
  logic [7:0] b_data, b_bus_in, b_bus_out;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  logic [3:0] mar_a, mar_b;
  logic [4:0] a_cnt, b_cnt;
  logic       force3 = 1'b0;
  logic       b_preload = 1'b0;
  logic [3:0] b_addr_log [64];
  int         b_lar_cnt = 0;
  int         a_wr = 0, b_wr = 0;
  int         excl_bad = 0;
  int         cyc = 0;
  int         vecs = 0, errs = 0;

  always #5 clk = ~clk;

  ram_loader #(.LENGTH(16), .START_ADDR(4'd0)) u_a (
    .clk(clk), .clear(clear), .start(a_start), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .bus_in(a_bus_in), .bus_out(a_bus_out), .bus_drive(a_drive),
    .load_addr_reg(a_lar), .control_signal(a_cs), .output_enable(a_oe),
    .busy(a_busy), .done(a_done), .error(a_error)
  );

  ram_loader #(.LENGTH(4), .START_ADDR(4'd14)) u_b (
    .clk(clk), .clear(clear), .start(b_start), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .bus_in(b_bus_in), .bus_out(b_bus_out), .bus_drive(b_drive),
    .load_addr_reg(b_lar), .control_signal(b_cs), .output_enable(b_oe),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  // Sources hand out base+n for the n-th accepted byte since the last clear.
  assign a_data   = 8'h10 + {3'b000, a_cnt};
  assign b_data   = 8'hC0 + {3'b000, b_cnt};
  assign a_bus_in = !a_oe ? 8'h00 : ((force3 && mar_a == 4'd3) ? 8'hFF : mem_a[mar_a]);
  assign b_bus_in = b_oe ? mem_b[mar_b] : 8'h00;

  // RAM, MAR and source models plus strobe bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_lar) mar_a <= a_bus_out[3:0];
    if (a_cs) begin
      mem_a[mar_a] <= a_bus_out;
      a_wr <= a_wr + 1;
    end
    if (b_lar) mar_b <= b_bus_out[3:0];
    if (b_preload) begin
      for (int k = 0; k < 16; k++) mem_b[k] <= 8'hAA;
    end else if (b_cs) begin
      mem_b[mar_b] <= b_bus_out;
    end
    if (b_cs) b_wr <= b_wr + 1;
    if (b_lar && b_lar_cnt < 64) begin
      b_addr_log[b_lar_cnt] <= b_bus_out[3:0];
      b_lar_cnt <= b_lar_cnt + 1;
    end
    if (clear) begin
      a_cnt <= 5'd0;
      b_cnt <= 5'd0;
    end else begin
      if (a_valid && a_ready) a_cnt <= a_cnt + 5'd1;
      if (b_valid && b_ready) b_cnt <= b_cnt + 5'd1;
    end
    if ((int'(a_lar) + int'(a_cs) + int'(a_oe)) > 1 ||
        (int'(b_lar) + int'(b_cs) + int'(b_oe)) > 1)
      excl_bad <= excl_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done_a(input int c0, output int lat);
    int k = 0;
    while (!a_done && k < 400) begin
      tick();
      k++;
    end
    lat = cyc - c0;
  endtask

  task automatic wait_done_b(input int c0, output int lat);
    int k = 0;
    while (!b_done && k < 200) begin
      tick();
      k++;
    end
    lat = cyc - c0;
  endtask

  initial begin
    int c0, lat, k, wr0;

    // Reset state
    tick(); tick();
    check("rst_bus_out", 32'(a_bus_out), 32'h0);
    check("rst_drive", 32'(a_drive), 32'h0);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_done", 32'(a_done), 32'h0);
    check("rst_ready", 32'(a_ready), 32'h0);
    check("rst_strobes", {29'b0, a_lar, a_cs, a_oe}, 32'h0);
    check("rst_error", 32'(a_error), 32'h0);
    clear = 1'b0;
    b_preload = 1'b1;
    tick();
    b_preload = 1'b0;

    // Full 16-byte load with in_valid held high, plus a dropped start while busy
    a_valid = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    c0 = cyc;
    check("a_first_lar", 32'(a_lar), 32'h1);
    check("a_first_addr", 32'(a_bus_out), 32'h0);
    check("a_first_busy", 32'(a_busy), 32'h1);
    for (int i = 0; i < 9; i++) tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done_a(c0, lat);
    check("a_latency", 32'(lat), 32'(LAT_A));
    check("a_error", 32'(a_error), 32'h0);
    check("a_busy_end", 32'(a_busy), 32'h0);
    for (int i = 0; i < 16; i++) check("a_mem", 32'(mem_a[i]), 32'(8'h10 + i));
    for (int i = 0; i < 6; i++) tick();
    check("a_once_busy", 32'(a_busy), 32'h0);
    check("a_once_writes", 32'(a_wr), 32'd16);
    check("a_done_sticky", 32'(a_done), 32'h1);

    // LENGTH=4 from address 14 wraps to 0,1
    b_valid = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    c0 = cyc;
    wait_done_b(c0, lat);
    check("b_latency", 32'(lat), 32'(LAT_B));
    check("b_lar_count", 32'(b_lar_cnt), 32'(LAR_B));
    check("b_addr0", 32'(b_addr_log[0]), 32'd14);
    check("b_addr1", 32'(b_addr_log[1]), 32'd15);
    check("b_addr2", 32'(b_addr_log[2]), 32'd0);
    check("b_addr3", 32'(b_addr_log[3]), 32'd1);
    check("b_mem14", 32'(mem_b[14]), 32'hC0);
    check("b_mem15", 32'(mem_b[15]), 32'hC1);
    check("b_mem0", 32'(mem_b[0]), 32'hC2);
    check("b_mem1", 32'(mem_b[1]), 32'hC3);
    check("b_mem2_untouched", 32'(mem_b[2]), 32'hAA);
    check("b_mem13_untouched", 32'(mem_b[13]), 32'hAA);

    // Backpressure: in_valid low for 5 cycles before byte 2
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_b_done", 32'(b_done), 32'h0);
    wr0 = b_wr;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    c0 = cyc;
    k = 0;
    while (b_wr != wr0 + 2 && k < 50) begin
      tick();
      k++;
    end
    b_valid = 1'b0;
    k = 0;
    while (!b_ready && k < 10) begin
      tick();
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_hold", 32'(b_ready), 32'h1);
      tick();
    end
    b_valid = 1'b1;
    check("bp_ready_6th", 32'(b_ready), 32'h1);
    tick();
    check("bp_ready_drop", 32'(b_ready), 32'h0);
    check("bp_write", 32'(b_cs), 32'h1);
    wait_done_b(c0, lat);
    check("bp_latency", 32'(lat), 32'(LAT_B + 5));
    check("bp_writes", 32'(b_wr - wr0), 32'd4);
    check("bp_mem0", 32'(mem_b[0]), 32'hC2);

    // clear during the WRITE cycle of byte 7
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wr0 = a_wr;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    k = 0;
    while (!(a_cs && a_wr == wr0 + 7) && k < 100) begin
      tick();
      k++;
    end
    check("abort_reached_w7", 32'(a_cs), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_outs", {21'b0, a_bus_out, a_drive, a_lar, a_cs}, 32'h0);
    check("abort_flags", {27'b0, a_oe, a_busy, a_done, a_error, a_ready}, 32'h0);
    tick();
    check("abort_stays_idle", 32'(a_busy), 32'h0);

    // clear and start together: clear wins
    clear = 1'b1;
    a_start = 1'b1;
    tick();
    clear = 1'b0;
    a_start = 1'b0;
    check("clr_beats_start", 32'(a_busy), 32'h0);

    // Restart after abort begins at START_ADDR
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    c0 = cyc;
    check("restart_lar", 32'(a_lar), 32'h1);
    check("restart_addr", 32'(a_bus_out), 32'h0);
    wait_done_a(c0, lat);
    check("restart_latency", 32'(lat), 32'(LAT_A));
    check("restart_mem7", 32'(mem_a[7]), 32'h17);

`ifdef RAM_LOADER_VERIFY_EN
    // Readback of address 3 corrupted -> checksum mismatch
    clear = 1'b1;
    tick();
    clear = 1'b0;
    force3 = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    c0 = cyc;
    wait_done_a(c0, lat);
    check("verify_latency", 32'(lat), 32'(LAT_A));
    check("verify_error", 32'(a_error), 32'h1);
    check("verify_done", 32'(a_done), 32'h1);
    force3 = 1'b0;
`endif

    check("strobe_exclusive", 32'(excl_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Bus-master program loader for the 16-byte SAP RAM. It accepts a stream of program bytes over a valid/ready handshake and drives the shared 8-bit bus, the MAR load strobe and the RAM write strobe, so that RAM is filled in run mode without dipswitch entry. The loader sits beside the controller on the bus and owns the bus only while `busy`. An optional readback pass checksums the RAM contents after loading.

## Interface
Parameters:
- `LENGTH`, 16: number of bytes loaded per run. Legal range is 1..16.
- `START_ADDR`, 0: first RAM address, 4-bit.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `clear` in 1: reset. Synchronous and active-high.
- `start` in 1: single-cycle request to begin a load. Ignored while `busy`.
- `in_data` in 8: program byte from the source.
- `in_valid` in 1: source has a byte on `in_data`.
- `in_ready` out 1: loader accepts a byte this cycle.
- `bus_in` in 8: RAM `bus_out`, used only for readback.
- `bus_out` out 8: value the loader drives onto the bus.
- `bus_drive` out 1: loader owns the bus; `bus_out` is valid.
- `load_addr_reg` out 1: MAR load strobe.
- `control_signal` out 1: RAM write strobe. RAM writes during the high phase of `clk`.
- `output_enable` out 1: RAM drives the bus (readback only).
- `busy` out 1: a sequence is in progress.
- `done` out 1: sticky. Set at the end of a sequence.
- `error` out 1: sticky. Set on a checksum mismatch.

## Operation
- State machine states: IDLE, ADDR, WAIT_DATA, WRITE, NEXT, plus V_ADDR, V_READ and CHECK when verify is compiled in.
- IDLE:
  - `start` clears `done`, `error`, the index and the checksum, then goes to ADDR.
- ADDR:
  - Drives `bus_out = {4'b0, addr}` with `bus_drive=1` and `load_addr_reg=1`.
  - `addr = (START_ADDR + index) mod 16`. The 4-bit wrap is intentional.
  - Goes to WAIT_DATA.
- WAIT_DATA:
  - Holds `in_ready=1` and stays until `in_valid & in_ready` at a clock edge.
  - On that edge, latches `in_data` into the data register and adds it to the 8-bit checksum (mod 256).
  - Goes to WRITE.
- WRITE:
  - Drives `bus_out = data` with `bus_drive=1` and `control_signal=1` for exactly one cycle.
  - Goes to NEXT.
- NEXT:
  - If `index == LENGTH-1`, goes to V_ADDR when verify is enabled, otherwise sets `done` and goes to IDLE.
  - Otherwise increments `index` and goes to ADDR.
- V_ADDR:
  - Behaves like ADDR for the current readback index.
- V_READ:
  - Drives `bus_drive=0` and `output_enable=1`.
  - On the clock edge, adds `bus_in` to the readback sum.
  - After the last index, goes to CHECK.
- CHECK:
  - Sets `error` if `readback sum != checksum`.
  - Sets `done` and goes to IDLE.
- All strobes are registered Moore outputs decoded from the state. At most one of `load_addr_reg`, `control_signal`, `output_enable` is high in any cycle.
- Outside the active states listed above, `bus_out` is 0 and `bus_drive` is 0.
- `busy` is high in every state except IDLE.

## Timing
- Reset value of every output is 0 (`bus_out` is 8'h00). The state returns to IDLE; index and sums reset to 0.
- `clear` during a sequence aborts it on the next edge. Bytes already written stay in RAM. `done` and `error` read 0.
- `clear` and `start` in the same cycle: `clear` wins.
- Latency:
  - Minimum 3 cycles per byte (ADDR, WAIT_DATA, WRITE) plus 1 NEXT cycle, so 4·LENGTH cycles from `start` to `done` when `in_valid` is held high.
  - Verify adds 2·LENGTH + 1 cycles.
- Backpressure: each cycle `in_valid` stays low extends WAIT_DATA by one cycle. `in_ready` never drops while in WAIT_DATA.
- `done` rises the cycle after the final NEXT (or CHECK). It stays high until the next accepted `start` or `clear`.
- A `start` that arrives while `busy` is dropped, not queued.

## Configuration
- `RAM_LOADER_VERIFY_EN`:
  - Defined: the V_ADDR, V_READ and CHECK states are compiled in, and `error` reports a checksum mismatch.
  - Undefined: those states are removed, `output_enable` and `error` are tied to 0, and `done` follows the last NEXT.

## Test plan
- LENGTH=16, START_ADDR=0, `in_valid` held high, stream 8'h10..8'h1F -> RAM address i holds 8'h10+i, `done` rises 64 cycles after `start`, `error=0`.
- LENGTH=4, START_ADDR=14 -> `load_addr_reg` pulses carry addresses 14, 15, 0, 1 on `bus_out[3:0]`. Addresses 2..13 are untouched.
- `in_valid` low for 5 cycles before byte 2 -> `in_ready` stays high for 6 cycles, the write occurs once, total latency grows by 5.
- Verify enabled, RAM model forces address 3 to read back 8'hFF instead of the loaded 8'h13 -> `error=1` and `done=1` after CHECK.
- `clear` asserted in the WRITE cycle of byte 7 -> the next cycle has all outputs 0 and the state in IDLE. A subsequent `start` restarts at START_ADDR.
- `start` pulsed while `busy` -> no effect. The sequence completes exactly once.
